// File: rtl/bist_sequencer_pkg.sv
// Shared types and helpers for the scan-BIST sequencer.
// Provides the FSM state enum, the registered control-output bundle,
// default signature settings and the counter width helper.
package bist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      SHIFT,
      CAPTURE,
      UNLOAD,
      COMPARE,
      DONE
   } bist_state_e;

   // Control outputs that are decoded from the FSM state and then registered
   typedef struct packed {
      logic running;
      logic scan_en;
      logic lfsr_load;
      logic misr_clear;
      logic misr_en;
      logic bist_end;
   } bist_ctrl_t;

   localparam int         DEFAULT_SIG_WIDTH       = 8;
   localparam logic [7:0] DEFAULT_SIGNATURE_VALID = 8'h27;

   // Bits needed to hold values 0..max_val inclusive (never less than 1)
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/bist_sequencer_if.sv
// Handshake and control bundle between the BIST sequencer and its
// environment (start request, MISR signature, LFSR/MISR/UUT controls).
// Optional macro BIST_ABORT_EN adds the bist_abort input and aborted flag.
interface bist_sequencer_if #(
   parameter int SIG_WIDTH = 8,
   parameter int CNT_W     = 5
);
   logic                 bist_start;
   logic [SIG_WIDTH-1:0] signature;
   logic                 running;
   logic                 scan_en;
   logic                 lfsr_load;
   logic                 misr_clear;
   logic                 misr_en;
   logic [CNT_W-1:0]     pattern_cnt;
   logic                 bist_end;
   logic                 pass_fail;
`ifdef BIST_ABORT_EN
   logic                 bist_abort;
   logic                 aborted;

   // Environment side: requests a session and supplies the signature
   modport master (
      output bist_start, signature, bist_abort,
      input  running, scan_en, lfsr_load, misr_clear, misr_en,
             pattern_cnt, bist_end, pass_fail, aborted
   );
   // Sequencer side
   modport slave (
      input  bist_start, signature, bist_abort,
      output running, scan_en, lfsr_load, misr_clear, misr_en,
             pattern_cnt, bist_end, pass_fail, aborted
   );
`else
   // Environment side: requests a session and supplies the signature
   modport master (
      output bist_start, signature,
      input  running, scan_en, lfsr_load, misr_clear, misr_en,
             pattern_cnt, bist_end, pass_fail
   );
   // Sequencer side
   modport slave (
      input  bist_start, signature,
      output running, scan_en, lfsr_load, misr_clear, misr_en,
             pattern_cnt, bist_end, pass_fail
   );
`endif
endinterface

// File: rtl/bist_phase_counter.sv
// Loadable up-counter with terminal-count flag.
// At MAX_VAL the counter either wraps to zero (WRAP=1) or saturates (WRAP=0);
// tc is high while the count equals TERMINAL.
module bist_phase_counter #(
   parameter int WIDTH    = 4,
   parameter int TERMINAL = 0,
   parameter int MAX_VAL  = 0,
   parameter bit WRAP     = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             tc
);
   localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERMINAL);
   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: clear has priority, then increment with wrap or saturation
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         if (cnt_q == MAX_V) begin
            cnt_d = WRAP ? '0 : cnt_q;
         end else begin
            cnt_d = cnt_q + WIDTH'(1);
         end
      end
   end

   // Count register, cleared asynchronously by the active-low reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;
   assign tc    = (cnt_q == TERM_V);

endmodule

// File: rtl/bist_sequencer.sv
// Scan-BIST sequencer: seed load, NUM_PATTERNS shift/capture loops, a final
// CHAIN_LEN-cycle unload, then a full-width signature compare.
// All control outputs are decoded from the next state and registered, so no
// input reaches an output combinationally.
// Optional macro BIST_ABORT_EN adds bist_abort/aborted: an abort in any active
// state jumps straight to DONE with pass_fail cleared.
module bist_sequencer
   import bist_pkg::*;
#(
   parameter int                   CHAIN_LEN       = 8,
   parameter int                   NUM_PATTERNS    = 16,
   parameter int                   SIG_WIDTH       = DEFAULT_SIG_WIDTH,
   parameter logic [SIG_WIDTH-1:0] SIGNATURE_VALID = DEFAULT_SIGNATURE_VALID
) (
   input  logic              clock,
   input  logic              reset,
   bist_sequencer_if.slave   bus
);
   localparam int CNT_W   = cnt_width(NUM_PATTERNS);
   localparam int SHIFT_W = cnt_width(CHAIN_LEN);

   bist_state_e        state_q, state_d;
   bist_ctrl_t         ctrl_q, ctrl_d;
   logic               pass_fail_q, pass_fail_d;
   logic               abort_hit;
   logic               shift_tc, pat_tc;
   logic [SHIFT_W-1:0] shift_cnt;
   logic [CNT_W-1:0]   pat_cnt;
   logic               unused_shift_cnt;

   // Only the terminal flag of the shift counter steers the FSM
   assign unused_shift_cnt = ^shift_cnt;

`ifdef BIST_ABORT_EN
   logic aborted_q, aborted_d;
   assign abort_hit = bus.bist_abort && (state_q != IDLE) && (state_q != DONE);
`else
   assign abort_hit = 1'b0;
`endif

   // Shift cycles within one pattern (and the unload); wraps after CHAIN_LEN
   bist_phase_counter #(
      .WIDTH    (SHIFT_W),
      .TERMINAL (CHAIN_LEN - 1),
      .MAX_VAL  (CHAIN_LEN - 1),
      .WRAP     (1'b1)
   ) u_shift_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (state_d == INIT),
      .inc   ((state_q == SHIFT) || (state_q == UNLOAD)),
      .count (shift_cnt),
      .tc    (shift_tc)
   );

   // Completed captures; saturates at NUM_PATTERNS
   bist_phase_counter #(
      .WIDTH    (CNT_W),
      .TERMINAL (NUM_PATTERNS - 1),
      .MAX_VAL  (NUM_PATTERNS),
      .WRAP     (1'b0)
   ) u_pat_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (state_d == INIT),
      .inc   (state_q == CAPTURE),
      .count (pat_cnt),
      .tc    (pat_tc)
   );

   // State, registered outputs and result flags
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         ctrl_q      <= '0;
         pass_fail_q <= 1'b0;
`ifdef BIST_ABORT_EN
         aborted_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ctrl_q      <= ctrl_d;
         pass_fail_q <= pass_fail_d;
`ifdef BIST_ABORT_EN
         aborted_q   <= aborted_d;
`endif
      end
   end

   // Next-state: schedule walk, abort overrides any normal transition
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.bist_start) state_d = INIT;
         INIT:    state_d = SHIFT;
         SHIFT:   if (shift_tc) state_d = CAPTURE;
         CAPTURE: state_d = pat_tc ? UNLOAD : SHIFT;
         UNLOAD:  if (shift_tc) state_d = COMPARE;
         COMPARE: state_d = DONE;
         DONE:    if (!bus.bist_start) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort_hit) begin
         state_d = DONE;
      end
   end

   // Output decode from the next state so the registered outputs track state_q
   always_comb begin
      ctrl_d = '0;
      unique case (state_d)
         INIT: begin
            ctrl_d.running    = 1'b1;
            ctrl_d.lfsr_load  = 1'b1;
            ctrl_d.misr_clear = 1'b1;
         end
         SHIFT, UNLOAD: begin
            ctrl_d.running = 1'b1;
            ctrl_d.scan_en = 1'b1;
            ctrl_d.misr_en = 1'b1;
         end
         CAPTURE: begin
            ctrl_d.running = 1'b1;
            ctrl_d.misr_en = 1'b1;
         end
         COMPARE: ctrl_d.running  = 1'b1;
         DONE:    ctrl_d.bist_end = 1'b1;
         default: ctrl_d = '0;
      endcase
   end

   // Result flags: cleared on entry to INIT, set by compare or abort
   always_comb begin
      pass_fail_d = pass_fail_q;
`ifdef BIST_ABORT_EN
      aborted_d   = aborted_q;
`endif
      if (state_d == INIT) begin
         pass_fail_d = 1'b0;
`ifdef BIST_ABORT_EN
         aborted_d   = 1'b0;
`endif
      end else if (abort_hit) begin
         pass_fail_d = 1'b0;
`ifdef BIST_ABORT_EN
         aborted_d   = 1'b1;
`endif
      end else if (state_q == COMPARE) begin
         pass_fail_d = (bus.signature == SIGNATURE_VALID);
      end
   end

   assign bus.running     = ctrl_q.running;
   assign bus.scan_en     = ctrl_q.scan_en;
   assign bus.lfsr_load   = ctrl_q.lfsr_load;
   assign bus.misr_clear  = ctrl_q.misr_clear;
   assign bus.misr_en     = ctrl_q.misr_en;
   assign bus.bist_end    = ctrl_q.bist_end;
   assign bus.pass_fail   = pass_fail_q;
   assign bus.pattern_cnt = pat_cnt;
`ifdef BIST_ABORT_EN
   assign bus.aborted     = aborted_q;
`endif

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer: default schedule (8x16) and a minimal
// 1x1 schedule run side by side. Abort scenario compiled when BIST_ABORT_EN
// is defined.
module tb_bist_sequencer;
   import bist_pkg::*;

   logic clock;
   logic reset;
   int   checks;
   int   errors;

   bist_sequencer_if #(.SIG_WIDTH(8), .CNT_W(5)) bif ();
   bist_sequencer_if #(.SIG_WIDTH(8), .CNT_W(1)) sif ();

   bist_sequencer #(
      .CHAIN_LEN(8), .NUM_PATTERNS(16), .SIG_WIDTH(8), .SIGNATURE_VALID(8'h27)
   ) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bif)
   );

   bist_sequencer #(
      .CHAIN_LEN(1), .NUM_PATTERNS(1), .SIG_WIDTH(8), .SIGNATURE_VALID(8'h27)
   ) u_small (
      .clock (clock),
      .reset (reset),
      .bus   (sif)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Runs one default session; the golden-or-not value is presented only
   // while COMPARE is visible, its complement at all other times.
   task automatic run_session(input logic [7:0] sig_cmp, input bit hold,
                              output int lat, output int loads, output int clears,
                              output int caps, output int maxrun);
      int run;
      bif.signature  = ~sig_cmp;
      bif.bist_start = 1'b1;
      tick();
      if (!hold) bif.bist_start = 1'b0;
      lat = 0; loads = 0; clears = 0; caps = 0; maxrun = 0; run = 0;
      while (bif.bist_end !== 1'b1 && lat < 400) begin
         if (bif.lfsr_load === 1'b1) loads++;
         if (bif.misr_clear === 1'b1) clears++;
         if (bif.running === 1'b1 && bif.scan_en === 1'b0 && bif.misr_en === 1'b1) begin
            caps++;
            run++;
            if (run > maxrun) maxrun = run;
         end else begin
            run = 0;
         end
         if (bif.running === 1'b1 && bif.scan_en === 1'b0 && bif.misr_en === 1'b0 &&
             bif.lfsr_load === 1'b0)
            bif.signature = sig_cmp;
         else
            bif.signature = ~sig_cmp;
         tick();
         lat++;
      end
      $display("session sig=%h lat=%0d loads=%0d caps=%0d pass_fail=%0b pattern_cnt=%0d",
               sig_cmp, lat, loads, caps, bif.pass_fail, bif.pattern_cnt);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      checks++;
      if (bif.running !== 1'b0 || bif.scan_en !== 1'b0 || bif.misr_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got run=%b scan=%b misr=%b expected 0 0 0",
                  bif.running, bif.scan_en, bif.misr_en);
      end
      checks++;
      if (bif.bist_end !== 1'b0 || bif.pass_fail !== 1'b0 || bif.pattern_cnt !== 5'd0) begin
         errors++;
         $display("FAIL reset_status: got end=%b pf=%b cnt=%0d expected 0 0 0",
                  bif.bist_end, bif.pass_fail, bif.pattern_cnt);
      end
      reset = 1'b1;
      tick();
      $display("reset released");
   endtask

   task automatic test_pass();
      int lat, loads, clears, caps, maxrun;
      run_session(8'h27, 1'b0, lat, loads, clears, caps, maxrun);
      checks++;
      if (lat !== 154) begin errors++; $display("FAIL latency: got %0d expected 154", lat); end
      checks++;
      if (loads !== 1) begin errors++; $display("FAIL lfsr_load_cycles: got %0d expected 1", loads); end
      checks++;
      if (clears !== 1) begin errors++; $display("FAIL misr_clear_cycles: got %0d expected 1", clears); end
      checks++;
      if (caps !== 16) begin errors++; $display("FAIL capture_cycles: got %0d expected 16", caps); end
      checks++;
      if (maxrun !== 1) begin errors++; $display("FAIL capture_run_len: got %0d expected 1", maxrun); end
      checks++;
      if (bif.pass_fail !== 1'b1) begin errors++; $display("FAIL pass_golden: got %b expected 1", bif.pass_fail); end
      checks++;
      if (bif.pattern_cnt !== 5'd16) begin
         errors++; $display("FAIL pattern_cnt: got %0d expected 16", bif.pattern_cnt);
      end
      tick();
      checks++;
      if (bif.bist_end !== 1'b0) begin errors++; $display("FAIL done_exit: got %b expected 0", bif.bist_end); end
   endtask

   task automatic test_fail();
      logic [7:0] bad [3];
      int lat, loads, clears, caps, maxrun;
      bad = '{8'h26, 8'hA7, 8'h00};
      for (int i = 0; i < 3; i++) begin
         run_session(bad[i], 1'b0, lat, loads, clears, caps, maxrun);
         checks++;
         if (lat !== 154) begin
            errors++; $display("FAIL latency_bad: sig=%h got %0d expected 154", bad[i], lat);
         end
         checks++;
         if (bif.pass_fail !== 1'b0) begin
            errors++; $display("FAIL pass_bad: sig=%h got %b expected 0", bad[i], bif.pass_fail);
         end
         tick();
      end
   endtask

   task automatic test_hold();
      int lat, loads, clears, caps, maxrun;
      run_session(8'h27, 1'b1, lat, loads, clears, caps, maxrun);
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (bif.bist_end !== 1'b1 || bif.running !== 1'b0) begin
            errors++;
            $display("FAIL hold_done: cycle %0d got end=%b run=%b expected 1 0",
                     i, bif.bist_end, bif.running);
         end
      end
      bif.bist_start = 1'b0;
      tick();
      checks++;
      if (bif.bist_end !== 1'b0) begin errors++; $display("FAIL hold_exit: got %b expected 0", bif.bist_end); end
      checks++;
      if (bif.pass_fail !== 1'b1) begin errors++; $display("FAIL hold_pf_kept: got %b expected 1", bif.pass_fail); end
      tick();
      checks++;
      if (bif.running !== 1'b0) begin errors++; $display("FAIL hold_idle: got run=%b expected 0", bif.running); end
      $display("hold session done");
   endtask

   task automatic test_small();
      logic [2:0] exp_scan;
      exp_scan = 3'b101;
      sif.signature  = 8'h27;
      sif.bist_start = 1'b1;
      tick();
      sif.bist_start = 1'b0;
      checks++;
      if (sif.lfsr_load !== 1'b1) begin errors++; $display("FAIL small_init: got %b expected 1", sif.lfsr_load); end
      for (int i = 2; i >= 0; i--) begin
         tick();
         checks++;
         if (sif.scan_en !== exp_scan[i]) begin
            errors++; $display("FAIL small_scan: step %0d got %b expected %b", 2 - i, sif.scan_en, exp_scan[i]);
         end
      end
      tick();
      checks++;
      if (sif.bist_end !== 1'b0) begin errors++; $display("FAIL small_early_end: got %b expected 0", sif.bist_end); end
      tick();
      checks++;
      if (sif.bist_end !== 1'b1 || sif.pass_fail !== 1'b1 || sif.pattern_cnt !== 1'b1) begin
         errors++;
         $display("FAIL small_end: got end=%b pf=%b cnt=%0d expected 1 1 1",
                  sif.bist_end, sif.pass_fail, sif.pattern_cnt);
      end
      tick();
      $display("small session done");
   endtask

`ifdef BIST_ABORT_EN
   task automatic test_abort();
      int n;
      bif.signature  = 8'h27;
      bif.bist_start = 1'b1;
      tick();
      bif.bist_start = 1'b0;
      repeat (50) tick();
      bif.bist_abort = 1'b1;
      tick();
      bif.bist_abort = 1'b0;
      checks++;
      if (bif.bist_end !== 1'b1 || bif.running !== 1'b0) begin
         errors++; $display("FAIL abort_done: got end=%b run=%b expected 1 0", bif.bist_end, bif.running);
      end
      checks++;
      if (bif.pass_fail !== 1'b0 || bif.aborted !== 1'b1) begin
         errors++; $display("FAIL abort_flags: got pf=%b ab=%b expected 0 1", bif.pass_fail, bif.aborted);
      end
      tick();
      checks++;
      if (bif.aborted !== 1'b1) begin errors++; $display("FAIL abort_sticky: got %b expected 1", bif.aborted); end
      bif.bist_start = 1'b1;
      tick();
      bif.bist_start = 1'b0;
      checks++;
      if (bif.lfsr_load !== 1'b1 || bif.aborted !== 1'b0) begin
         errors++; $display("FAIL abort_clear: got load=%b ab=%b expected 1 0", bif.lfsr_load, bif.aborted);
      end
      n = 0;
      while (bif.bist_end !== 1'b1 && n < 400) begin tick(); n++; end
      checks++;
      if (n !== 154 || bif.pass_fail !== 1'b1) begin
         errors++; $display("FAIL abort_rerun: got lat=%0d pf=%b expected 154 1", n, bif.pass_fail);
      end
      tick();
      $display("abort session done");
   endtask
`endif

   task automatic test_reset_mid();
      bif.signature  = 8'h27;
      bif.bist_start = 1'b1;
      tick();
      bif.bist_start = 1'b0;
      repeat (20) tick();
      checks++;
      if (bif.scan_en !== 1'b1 || bif.pattern_cnt !== 5'd2) begin
         errors++; $display("FAIL mid_shift: got scan=%b cnt=%0d expected 1 2", bif.scan_en, bif.pattern_cnt);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (bif.running !== 1'b0 || bif.scan_en !== 1'b0 || bif.misr_en !== 1'b0 ||
          bif.bist_end !== 1'b0 || bif.pattern_cnt !== 5'd0) begin
         errors++;
         $display("FAIL mid_reset_async: got run=%b scan=%b misr=%b end=%b cnt=%0d expected all 0",
                  bif.running, bif.scan_en, bif.misr_en, bif.bist_end, bif.pattern_cnt);
      end
      tick();
      checks++;
      if (bif.running !== 1'b0 || bif.scan_en !== 1'b0 || bif.pattern_cnt !== 5'd0) begin
         errors++;
         $display("FAIL mid_reset_edge: got run=%b scan=%b cnt=%0d expected 0 0 0",
                  bif.running, bif.scan_en, bif.pattern_cnt);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (bif.running !== 1'b0) begin errors++; $display("FAIL mid_reset_idle: got %b expected 0", bif.running); end
      $display("mid-run reset done");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clock  = 1'b0;
      reset  = 1'b0;
      bif.bist_start = 1'b0;
      bif.signature  = 8'h00;
      sif.bist_start = 1'b0;
      sif.signature  = 8'h00;
`ifdef BIST_ABORT_EN
      bif.bist_abort = 1'b0;
      sif.bist_abort = 1'b0;
`endif
      test_reset();
      test_pass();
      test_fail();
      test_hold();
      test_small();
`ifdef BIST_ABORT_EN
      test_abort();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
